// File: rtl/gemm_mul_scheduler.sv
// Dot-product scheduler: streams K operand pairs through a shared NUM-lane multiplier
// array, masks the tail lanes of the last beat and returns one accumulated result per command.
module gemm_mul_scheduler #(
    parameter int unsigned INPUT_DATA_WIDTH  = 32,
    parameter int unsigned OUTPUT_DATA_WIDTH = 32,
    parameter int unsigned NUM               = 4,
    parameter int unsigned ACC_WIDTH         = 48,
    parameter int unsigned LEN_WIDTH         = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]                  cmd_len,
    input  logic                                  op_valid,
    output logic                                  op_ready,
    input  logic [NUM*INPUT_DATA_WIDTH-1:0]       op_a,
    input  logic [NUM*INPUT_DATA_WIDTH-1:0]       op_b,
    output logic [2*NUM*INPUT_DATA_WIDTH-1:0]     mul_data_out,
    input  logic [NUM*OUTPUT_DATA_WIDTH-1:0]      mul_data_in,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [ACC_WIDTH-1:0]                  res_data,
    output logic                                  busy
);
    localparam int unsigned IW  = INPUT_DATA_WIDTH;
    localparam int unsigned OW  = OUTPUT_DATA_WIDTH;
    localparam int unsigned LG  = $clog2(NUM);
    localparam int unsigned LW1 = LEN_WIDTH + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [LG-1:0]           tail_q, tail_d;
    logic [2*NUM*IW-1:0]     mul_data_out_q, mul_data_out_d;
    logic                    s1_v_q, s1_v_d;
    logic [NUM-1:0]          s1_mask_q, s1_mask_d;
    logic                    s2_v_q, s2_v_d;
    logic [NUM*OW-1:0]       s2_prod_q, s2_prod_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    op_ready_q, op_ready_d;
    logic                    res_valid_q, res_valid_d;
    logic [ACC_WIDTH-1:0]    res_data_q, res_data_d;
    logic                    busy_q, busy_d;
    logic                    op_hs;
    logic                    last_tail;
    logic [ACC_WIDTH-1:0]    beat_sum;

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        tail_d         = tail_q;
        mul_data_out_d = mul_data_out_q;
        s1_v_d         = 1'b0;
        s1_mask_d      = s1_mask_q;
        s2_v_d         = s1_v_q;
        s2_prod_d      = s2_prod_q;
        acc_d          = acc_q;
        beat_sum       = '0;
        op_hs          = (state_q == RUN) && op_valid && op_ready_q;
        last_tail      = (rem_q == LEN_WIDTH'(1)) && (tail_q != '0);

        // S1: register the accepted beat onto the array inputs, zeroing masked lanes
        if (op_hs) begin
            s1_v_d = 1'b1;
            for (int unsigned i = 0; i < NUM; i++) begin
                s1_mask_d[i] = !last_tail || (LG'(i) < tail_q);
                mul_data_out_d[i*IW +: IW]       = s1_mask_d[i] ? op_a[i*IW +: IW] : '0;
                mul_data_out_d[(NUM+i)*IW +: IW] = s1_mask_d[i] ? op_b[i*IW +: IW] : '0;
            end
        end

        // S2: capture products; masked lanes are zero whatever the array returns
        if (s1_v_q) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                s2_prod_d[i*OW +: OW] = mul_data_in[i*OW +: OW] & {OW{s1_mask_q[i]}};
            end
        end

        // S3: sign-extend, reduce and accumulate modulo 2^ACC_WIDTH
        for (int unsigned i = 0; i < NUM; i++) begin
            beat_sum = beat_sum + {{(ACC_WIDTH-OW){s2_prod_q[i*OW+OW-1]}}, s2_prod_q[i*OW +: OW]};
        end
        if (s2_v_q) begin
            acc_d = acc_q + beat_sum;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rem_d   = LEN_WIDTH'((LW1'(cmd_len) + LW1'(NUM - 1)) >> LG);
                    tail_d  = cmd_len[LG-1:0];
                    acc_d   = '0;
                    state_d = (cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (op_hs) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!s1_v_q && !s2_v_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        op_ready_d  = (state_d == RUN) && (rem_d != '0);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        res_data_d  = (state_d == DONE) ? acc_d : res_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            tail_q         <= '0;
            mul_data_out_q <= '0;
            s1_v_q         <= 1'b0;
            s1_mask_q      <= '0;
            s2_v_q         <= 1'b0;
            s2_prod_q      <= '0;
            acc_q          <= '0;
            cmd_ready_q    <= 1'b1;
            op_ready_q     <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            tail_q         <= tail_d;
            mul_data_out_q <= mul_data_out_d;
            s1_v_q         <= s1_v_d;
            s1_mask_q      <= s1_mask_d;
            s2_v_q         <= s2_v_d;
            s2_prod_q      <= s2_prod_d;
            acc_q          <= acc_d;
            cmd_ready_q    <= cmd_ready_d;
            op_ready_q     <= op_ready_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            busy_q         <= busy_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign op_ready     = op_ready_q;
    assign mul_data_out = mul_data_out_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_gemm_mul_scheduler.sv
// Bench for gemm_mul_scheduler: directed vector table, mid-run reset, and random
// commands checked against a plain-arithmetic dot-product model.
module tb_gemm_mul_scheduler;
    localparam int NUM = 4;
    localparam int IW  = 32;
    localparam int OW  = 32;
    localparam int AW  = 48;
    localparam int LW  = 16;

    logic                  clk;
    logic                  rst_n;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LW-1:0]         cmd_len;
    logic                  op_valid;
    logic                  op_ready;
    logic [NUM*IW-1:0]     op_a;
    logic [NUM*IW-1:0]     op_b;
    logic [2*NUM*IW-1:0]   mul_data_out;
    logic [NUM*OW-1:0]     mul_data_in;
    logic                  res_valid;
    logic                  res_ready;
    logic [AW-1:0]         res_data;
    logic                  busy;

    bit                    poison;
    int                    n_cmp;
    int                    n_fail;
    logic [31:0]           ea [0:15];
    logic [31:0]           eb [0:15];

    typedef struct {
        int                 k;
        bit                 gaps;
        int                 hold;
        bit                 poison;
        logic [11:0][31:0]  a;
        logic [11:0][31:0]  b;
        logic [AW-1:0]      exp;
    } vec_t;

    vec_t vecs [7];

    gemm_mul_scheduler #(
        .INPUT_DATA_WIDTH (IW),
        .OUTPUT_DATA_WIDTH(OW),
        .NUM              (NUM),
        .ACC_WIDTH        (AW),
        .LEN_WIDTH        (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .mul_data_out(mul_data_out),
        .mul_data_in (mul_data_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier array: low 32 bits of a*b; optionally returns garbage on zeroed upper lanes
    function automatic logic [31:0] arr_lane(input logic [31:0] a, input logic [31:0] b,
                                             input int lane, input bit p);
        if (p && lane >= 2 && a == 32'd0 && b == 32'd0) return 32'hDEAD;
        return a * b;
    endfunction

    for (genvar g = 0; g < NUM; g++) begin : g_arr
        assign mul_data_in[g*OW +: OW] = arr_lane(mul_data_out[g*IW +: IW],
                                                  mul_data_out[(NUM+g)*IW +: IW], g, poison);
    end

    function automatic logic [AW-1:0] ref_dot(input int k);
        longint      acc;
        logic [31:0] p;
        acc = 0;
        for (int j = 0; j < k; j++) begin
            p   = ea[j] * eb[j];
            acc = acc + longint'(int'(p));
        end
        return acc[AW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic do_cmd(input int k, input bit gaps, input int hold,
                          input logic [AW-1:0] exp, input string tag);
        int          beats;
        int          t;
        int          lat;
        int          j;
        int          tail;
        logic [AW-1:0] held;
        beats = (k + NUM - 1) / NUM;
        tail  = k % NUM;
        t = 0;
        while (!cmd_ready && t < 50) begin tick(); t++; end
        if (!cmd_ready) begin timeout_fail({tag, "_cmd_ready"}); return; end
        cmd_valid = 1'b1;
        cmd_len   = LW'(k);
        tick();
        cmd_valid = 1'b0;
        cmd_len   = LW'($urandom);
        for (int bt = 0; bt < beats; bt++) begin
            if (gaps) begin op_valid = 1'b0; tick(); end
            for (int i = 0; i < NUM; i++) begin
                j = bt * NUM + i;
                op_a[i*IW +: IW] = (j < k) ? ea[j] : $urandom;
                op_b[i*IW +: IW] = (j < k) ? eb[j] : $urandom;
            end
            op_valid = 1'b1;
            t = 0;
            while (!op_ready && t < 50) begin tick(); t++; end
            if (!op_ready) begin op_valid = 1'b0; timeout_fail({tag, "_op_ready"}); return; end
            tick();
            op_valid = 1'b0;
            if (bt == beats - 1 && tail != 0) begin
                for (int i = tail; i < NUM; i++) begin
                    chk($sformatf("%s_mask_a%0d", tag, i), 256'(mul_data_out[i*IW +: IW]), 256'(0));
                    chk($sformatf("%s_mask_b%0d", tag, i),
                        256'(mul_data_out[(NUM+i)*IW +: IW]), 256'(0));
                end
            end
        end
        lat = 0;
        while (!res_valid && lat < 20) begin tick(); lat++; end
        if (!res_valid) begin timeout_fail({tag, "_res_valid"}); return; end
        chk({tag, "_latency"}, 256'(lat), 256'((k == 0) ? 0 : 3));
        chk({tag, "_res_data"}, 256'(res_data), 256'(exp));
        if (k == 0) chk({tag, "_op_ready_k0"}, 256'(op_ready), 256'(1'b0));
        held = res_data;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold_data"}, 256'(res_data), 256'(held));
            chk({tag, "_hold_valid"}, 256'(res_valid), 256'(1'b1));
            chk({tag, "_hold_cmd_ready"}, 256'(cmd_ready), 256'(1'b0));
            chk({tag, "_hold_busy"}, 256'(busy), 256'(1'b1));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_post_valid"}, 256'(res_valid), 256'(1'b0));
        chk({tag, "_post_cmd_ready"}, 256'(cmd_ready), 256'(1'b1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 256'(cmd_ready), 256'(1'b1));
        chk({tag, "_op_ready"}, 256'(op_ready), 256'(1'b0));
        chk({tag, "_res_valid"}, 256'(res_valid), 256'(1'b0));
        chk({tag, "_res_data"}, 256'(res_data), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(1'b0));
        chk({tag, "_mul_out"}, 256'(mul_data_out), 256'(0));
    endtask

    initial begin
        int t;
        int k;
        n_cmp     = 0;
        n_fail    = 0;
        poison    = 1'b0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;

        for (int v = 0; v < 7; v++) begin
            vecs[v].k = 0; vecs[v].gaps = 1'b0; vecs[v].hold = 0; vecs[v].poison = 1'b0;
            vecs[v].a = '0; vecs[v].b = '0; vecs[v].exp = '0;
        end
        vecs[0].k = 8; vecs[0].exp = 48'd78;
        for (int j = 0; j < 4; j++) begin vecs[0].a[j] = 32'(j + 1); vecs[0].b[j] = 32'(j + 5); end
        for (int j = 4; j < 8; j++) begin vecs[0].a[j] = 32'd1; vecs[0].b[j] = 32'd2; end
        vecs[1].k = 6; vecs[1].poison = 1'b1; vecs[1].exp = 48'd32;
        for (int j = 0; j < 4; j++) begin vecs[1].a[j] = 32'd1; vecs[1].b[j] = 32'd3; end
        for (int j = 4; j < 6; j++) begin vecs[1].a[j] = 32'd2; vecs[1].b[j] = 32'd5; end
        vecs[2].k = 0; vecs[2].hold = 2; vecs[2].exp = 48'd0;
        vecs[3].k = 12; vecs[3].gaps = 1'b1; vecs[3].hold = 5; vecs[3].exp = 48'd156;
        for (int j = 0; j < 12; j++) begin vecs[3].a[j] = 32'(j + 1); vecs[3].b[j] = 32'd2; end
        vecs[4].k = 4; vecs[4].exp = 48'hFFFF_FFFF_FFEB;
        vecs[4].a[0] = 32'hFFFF_FFFD; vecs[4].b[0] = 32'd7;
        vecs[5].k = 5; vecs[5].exp = 48'hFFFF_FFFF_FFF6;
        for (int j = 0; j < 5; j++) begin vecs[5].a[j] = 32'h7FFF_FFFF; vecs[5].b[j] = 32'd2; end
        vecs[6].k = 3; vecs[6].hold = 1; vecs[6].exp = 48'hFFFF_FFFF_FFF9;
        vecs[6].a[0] = 32'd2; vecs[6].a[1] = 32'hFFFF_FFFF; vecs[6].a[2] = 32'd4;
        vecs[6].b[0] = 32'd3; vecs[6].b[1] = 32'd5;         vecs[6].b[2] = 32'hFFFF_FFFE;

        tick();
        tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < 16; j++) begin
                ea[j] = (j < 12) ? vecs[v].a[j] : 32'd0;
                eb[j] = (j < 12) ? vecs[v].b[j] : 32'd0;
            end
            poison = vecs[v].poison;
            do_cmd(vecs[v].k, vecs[v].gaps, vecs[v].hold, vecs[v].exp, $sformatf("vec%0d", v));
            poison = 1'b0;
        end

        // Asynchronous reset in the middle of a run, away from any clock edge
        t = 0;
        while (!cmd_ready && t < 50) begin tick(); t++; end
        cmd_valid = 1'b1;
        cmd_len   = LW'(8);
        tick();
        cmd_valid = 1'b0;
        op_a      = {32'd4, 32'd3, 32'd2, 32'd1};
        op_b      = {32'd9, 32'd9, 32'd9, 32'd9};
        op_valid  = 1'b1;
        t = 0;
        while (!op_ready && t < 50) begin tick(); t++; end
        tick();
        op_valid = 1'b0;
        chk("midrun_busy_before", 256'(busy), 256'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        #1;
        rst_n = 1'b1;
        tick();
        chk("midrun_cmd_ready_after", 256'(cmd_ready), 256'(1'b1));
        chk("midrun_busy_after", 256'(busy), 256'(1'b0));

        for (int r = 0; r < 25; r++) begin
            k = $urandom_range(0, 13);
            for (int j = 0; j < 16; j++) begin
                ea[j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
                eb[j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
            end
            do_cmd(k, 1'($urandom_range(0, 1)), $urandom_range(0, 3), ref_dot(k),
                   $sformatf("rnd%0d_k%0d", r, k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
